// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the datapath/memory.
// master = control unit, slave = datapath side.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Branch_ne;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [1:0] PCSource;
    logic [2:0] ALU_Control;
    logic [3:0] state;
    logic       inst_done;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, PCWriteCond, Branch_ne, IorD,
        output MemRead, MemWrite, IRWrite, MemtoReg,
        output RegDst, RegWrite, ALUSrc_A, ALUSrc_B,
        output PCSource, ALU_Control, state,
        output inst_done, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, PCWriteCond, Branch_ne, IorD,
        input  MemRead, MemWrite, IRWrite, MemtoReg,
        input  RegDst, RegWrite, ALUSrc_A, ALUSrc_B,
        input  PCSource, ALU_Control, state,
        input  inst_done, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM with memory-wait watchdog.
// Outputs are Moore-style per state, plus mem_ready-qualified strobes.
module mc_ctrl_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MRD = 4'd3,
        S_MWB = 4'd4,
        S_MWR = 4'd5,
        S_RX  = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_JMP = 4'd9,
        S_IX  = 4'd10,
        S_IWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_XOR = 3'b011;
    localparam logic [2:0] A_NOR = 3'b100;
    localparam logic [2:0] A_SRL = 3'b101;
    localparam logic [2:0] A_SUB = 3'b110;
    localparam logic [2:0] A_SLT = 3'b111;

    localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       ill_q, to_q;
    logic       set_ill, set_to;
    logic       wait_st, wdog_hit;

    // Branch resolution is done in the datapath from PCWriteCond/Branch_ne.
    wire unused_zero = bus.zero;

    assign wait_st  = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
    // Abort on the wait cycle that brings the count up to the limit.
    assign wdog_hit = wait_st && !bus.mem_ready && ((cnt + 8'd1) == WAIT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
            cnt   <= 8'd0;
            ill_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (set_ill) ill_q <= 1'b1;
            if (set_to)  to_q  <= 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = 8'd0;
        if (wait_st && !bus.mem_ready && !wdog_hit) cnt_nxt = cnt + 8'd1;
    end

    always_comb begin
        state_nxt       = state;
        set_ill         = 1'b0;
        set_to          = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.Branch_ne   = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrc_A    = 1'b0;
        bus.ALUSrc_B    = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALU_Control = 3'b000;
        bus.inst_done   = 1'b0;

        case (state)
            S_IF: begin
                if (wdog_hit) begin
                    set_to    = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    bus.MemRead     = 1'b1;
                    bus.ALUSrc_B    = 2'b01;
                    bus.ALU_Control = A_ADD;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_nxt   = S_ID;
                    end
                end
            end
            S_ID: begin
                bus.ALUSrc_B    = 2'b11;
                bus.ALU_Control = A_ADD;
                case (bus.opcode)
                    OP_R:           state_nxt = S_RX;
                    OP_LW, OP_SW:   state_nxt = S_MA;
                    OP_BEQ, OP_BNE: state_nxt = S_BR;
                    OP_J:           state_nxt = S_JMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI: state_nxt = S_IX;
                    default: begin
                        set_ill       = 1'b1;
                        bus.inst_done = 1'b1;
                        state_nxt     = S_IF;
                    end
                endcase
            end
            S_RX: begin
                bus.ALUSrc_A = 1'b1;
                state_nxt    = S_RWB;
                case (bus.funct)
                    F_ADD: bus.ALU_Control = A_ADD;
                    F_SUB: bus.ALU_Control = A_SUB;
                    F_AND: bus.ALU_Control = A_AND;
                    F_OR:  bus.ALU_Control = A_OR;
                    F_XOR: bus.ALU_Control = A_XOR;
                    F_NOR: bus.ALU_Control = A_NOR;
                    F_SLT: bus.ALU_Control = A_SLT;
                    F_SRL: bus.ALU_Control = A_SRL;
                    default: begin
                        set_ill       = 1'b1;
                        bus.inst_done = 1'b1;
                        state_nxt     = S_IF;
                    end
                endcase
            end
            S_RWB: begin
                bus.RegDst    = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.inst_done = 1'b1;
                state_nxt     = S_IF;
            end
            S_MA: begin
                bus.ALUSrc_A    = 1'b1;
                bus.ALUSrc_B    = 2'b10;
                bus.ALU_Control = A_ADD;
                state_nxt       = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                if (wdog_hit) begin
                    set_to    = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    if (bus.mem_ready) state_nxt = S_MWB;
                end
            end
            S_MWB: begin
                bus.MemtoReg  = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.inst_done = 1'b1;
                state_nxt     = S_IF;
            end
            S_MWR: begin
                if (wdog_hit) begin
                    set_to    = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    if (bus.mem_ready) begin
                        bus.inst_done = 1'b1;
                        state_nxt     = S_IF;
                    end
                end
            end
            S_BR: begin
                bus.ALUSrc_A    = 1'b1;
                bus.ALU_Control = A_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.Branch_ne   = (bus.opcode == OP_BNE);
                bus.inst_done   = 1'b1;
                state_nxt       = S_IF;
            end
            S_JMP: begin
                bus.PCWrite   = 1'b1;
                bus.PCSource  = 2'b10;
                bus.inst_done = 1'b1;
                state_nxt     = S_IF;
            end
            S_IX: begin
                bus.ALUSrc_A = 1'b1;
                bus.ALUSrc_B = 2'b10;
                state_nxt    = S_IWB;
                case (bus.opcode)
                    OP_ANDI: bus.ALU_Control = A_AND;
                    OP_ORI:  bus.ALU_Control = A_OR;
                    OP_SLTI: bus.ALU_Control = A_SLT;
                    default: bus.ALU_Control = A_ADD;
                endcase
            end
            S_IWB: begin
                bus.RegWrite  = 1'b1;
                bus.inst_done = 1'b1;
                state_nxt     = S_IF;
            end
            default: state_nxt = S_IF;
        endcase
    end

    assign bus.state       = state;
    assign bus.illegal_op  = ill_q;
    assign bus.mem_timeout = to_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mc_ctrl_if bus ();

    mc_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic rdy);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.zero = 1'b0;
        drive(6'd0, 6'd0, 1'b0);
        do_reset();
        drive(6'd0, 6'd0, 1'b0);
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", bus.state);
        end
        checks++;
        if ({bus.illegal_op, bus.mem_timeout, bus.inst_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000",
                     {bus.illegal_op, bus.mem_timeout, bus.inst_done});
        end
    endtask

    task automatic test_add();
        logic [3:0] st[4]  = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [2:0] alu[4] = '{3'b010, 3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 4; i++) begin
            drive(6'b000000, 6'b100000, 1'b1);
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("FAIL add_state[%0d] got=%0d exp=%0d", i, bus.state, st[i]);
            end
            checks++;
            if ({bus.RegWrite, bus.RegDst, bus.inst_done} !== {3{i == 3}}) begin
                errors++;
                $display("FAIL add_wr[%0d] got=%b exp=%b", i,
                         {bus.RegWrite, bus.RegDst, bus.inst_done}, {3{i == 3}});
            end
            checks++;
            if (bus.ALU_Control !== alu[i]) begin
                errors++;
                $display("FAIL add_alu[%0d] got=%b exp=%b", i, bus.ALU_Control, alu[i]);
            end
            if (i == 0) begin
                checks++;
                if ({bus.IRWrite, bus.PCWrite, bus.MemRead, bus.ALUSrc_B} !== 5'b11101) begin
                    errors++;
                    $display("FAIL add_fetch got=%b exp=11101",
                             {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.ALUSrc_B});
                end
            end
            tick();
        end
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL add_ret got=%0d exp=0", bus.state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] st[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        logic       rd[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++) begin
            drive(6'b100011, 6'd0, rd[i]);
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state, st[i]);
            end
            if (st[i] == 4'd3) begin
                checks++;
                if ({bus.MemRead, bus.IorD, bus.RegWrite} !== 3'b110) begin
                    errors++;
                    $display("FAIL lw_mrd[%0d] got=%b exp=110", i,
                             {bus.MemRead, bus.IorD, bus.RegWrite});
                end
            end
            if (i == 2) begin
                checks++;
                if ({bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control} !== 6'b110010) begin
                    errors++;
                    $display("FAIL lw_ma got=%b exp=110010",
                             {bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control});
                end
            end
            checks++;
            if ({bus.MemtoReg, bus.RegWrite, bus.inst_done} !== {3{i == 7}}) begin
                errors++;
                $display("FAIL lw_wb[%0d] got=%b exp=%b", i,
                         {bus.MemtoReg, bus.RegWrite, bus.inst_done}, {3{i == 7}});
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[2] = '{6'b000100, 6'b000101};
        bus.zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(ops[k], 6'd0, 1'b1);
            tick();
            drive(ops[k], 6'd0, 1'b1);
            checks++;
            if ({bus.state, bus.ALUSrc_B} !== {4'd1, 2'b11}) begin
                errors++;
                $display("FAIL br_id[%0d] got=%b exp=000111", k, {bus.state, bus.ALUSrc_B});
            end
            tick();
            drive(ops[k], 6'd0, 1'b1);
            checks++;
            if ({bus.state, bus.PCWriteCond, bus.PCSource, bus.ALU_Control, bus.inst_done}
                !== {4'd8, 1'b1, 2'b01, 3'b110, 1'b1}) begin
                errors++;
                $display("FAIL br_ctl[%0d] got=%b exp=%b", k,
                         {bus.state, bus.PCWriteCond, bus.PCSource, bus.ALU_Control, bus.inst_done},
                         {4'd8, 1'b1, 2'b01, 3'b110, 1'b1});
            end
            checks++;
            if (bus.Branch_ne !== (k == 1)) begin
                errors++;
                $display("FAIL br_ne[%0d] got=%b exp=%b", k, bus.Branch_ne, k == 1);
            end
            tick();
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jump();
        drive(6'b000010, 6'd0, 1'b1);
        tick();
        tick();
        drive(6'b000010, 6'd0, 1'b1);
        checks++;
        if ({bus.state, bus.PCWrite, bus.PCSource, bus.inst_done}
            !== {4'd9, 1'b1, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL jmp got=%b exp=%b",
                     {bus.state, bus.PCWrite, bus.PCSource, bus.inst_done},
                     {4'd9, 1'b1, 2'b10, 1'b1});
        end
        tick();
    endtask

    task automatic test_imm();
        logic [5:0] ops[4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [2:0] alu[4] = '{3'b010, 3'b000, 3'b001, 3'b111};
        for (int k = 0; k < 4; k++) begin
            drive(ops[k], 6'd0, 1'b1);
            tick();
            tick();
            drive(ops[k], 6'd0, 1'b1);
            checks++;
            if ({bus.state, bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control}
                !== {4'd10, 1'b1, 2'b10, alu[k]}) begin
                errors++;
                $display("FAIL ix[%0d] got=%b exp=%b", k,
                         {bus.state, bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control},
                         {4'd10, 1'b1, 2'b10, alu[k]});
            end
            tick();
            drive(ops[k], 6'd0, 1'b1);
            checks++;
            if ({bus.state, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.inst_done}
                !== {4'd11, 4'b1001}) begin
                errors++;
                $display("FAIL iwb[%0d] got=%b exp=%b", k,
                         {bus.state, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.inst_done},
                         {4'd11, 4'b1001});
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(6'b111111, 6'd0, 1'b1);
        tick();
        drive(6'b111111, 6'd0, 1'b1);
        checks++;
        if ({bus.state, bus.inst_done, bus.RegWrite, bus.illegal_op}
            !== {4'd1, 3'b100}) begin
            errors++;
            $display("FAIL ill_id got=%b exp=0001100",
                     {bus.state, bus.inst_done, bus.RegWrite, bus.illegal_op});
        end
        tick();
        drive(6'b000000, 6'b100000, 1'b1);
        checks++;
        if ({bus.state, bus.illegal_op} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL ill_op_flag got=%b exp=00001", {bus.state, bus.illegal_op});
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus.state, bus.illegal_op} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL ill_sticky got=%b exp=00001", {bus.state, bus.illegal_op});
        end
        do_reset();
        drive(6'b000000, 6'b001111, 1'b1);
        tick();
        tick();
        drive(6'b000000, 6'b001111, 1'b1);
        checks++;
        if ({bus.state, bus.inst_done, bus.RegWrite, bus.illegal_op}
            !== {4'd6, 3'b100}) begin
            errors++;
            $display("FAIL ill_rx got=%b exp=0110100",
                     {bus.state, bus.inst_done, bus.RegWrite, bus.illegal_op});
        end
        tick();
        drive(6'b000000, 6'b001111, 1'b1);
        checks++;
        if ({bus.state, bus.illegal_op, bus.RegWrite} !== {4'd0, 2'b10}) begin
            errors++;
            $display("FAIL ill_fn_flag got=%b exp=000010",
                     {bus.state, bus.illegal_op, bus.RegWrite});
        end
    endtask

    task automatic test_timeout();
        for (int run = 0; run < 2; run++) begin
            do_reset();
            drive(6'b101011, 6'd0, 1'b1);
            tick();
            tick();
            tick();
            for (int i = 0; i < 15; i++) begin
                drive(6'b101011, 6'd0, (run == 1) && (i == 14));
                checks++;
                if (bus.state !== 4'd5) begin
                    errors++;
                    $display("FAIL to_state[%0d.%0d] got=%0d exp=5", run, i, bus.state);
                end
                if (i < 14) begin
                    checks++;
                    if ({bus.MemWrite, bus.IorD, bus.inst_done} !== 3'b110) begin
                        errors++;
                        $display("FAIL to_wait[%0d.%0d] got=%b exp=110", run, i,
                                 {bus.MemWrite, bus.IorD, bus.inst_done});
                    end
                end
                tick();
            end
            drive(6'b101011, 6'd0, 1'b0);
            checks++;
            if ({bus.state, bus.mem_timeout, bus.MemWrite} !== {4'd0, run == 0, 1'b0}) begin
                errors++;
                $display("FAIL to_end[%0d] got=%b exp=%b", run,
                         {bus.state, bus.mem_timeout, bus.MemWrite},
                         {4'd0, run == 0, 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(6'b111111, 6'd0, 1'b1);
        tick();
        tick();
        drive(6'b100011, 6'd0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        drive(6'b100011, 6'd0, 1'b0);
        tick();
        checks++;
        if ({bus.state, bus.illegal_op} !== {4'd3, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre got=%b exp=00111", {bus.state, bus.illegal_op});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(6'b100011, 6'd0, 1'b0);
        checks++;
        if ({bus.state, bus.illegal_op, bus.mem_timeout, bus.inst_done,
             bus.RegWrite, bus.MemWrite, bus.IorD, bus.IRWrite} !== 11'd0) begin
            errors++;
            $display("FAIL mid_rst got=%b exp=0",
                     {bus.state, bus.illegal_op, bus.mem_timeout, bus.inst_done,
                      bus.RegWrite, bus.MemWrite, bus.IorD, bus.IRWrite});
        end
        drive(6'b100011, 6'd0, 1'b1);
        checks++;
        if ({bus.MemRead, bus.IRWrite, bus.PCWrite} !== 3'b111) begin
            errors++;
            $display("FAIL mid_fetch got=%b exp=111",
                     {bus.MemRead, bus.IRWrite, bus.PCWrite});
        end
        tick();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL mid_id got=%0d exp=1", bus.state);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_jump();
        test_imm();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time limit exceeded");
        $fatal(1);
    end

endmodule
